// File: rtl/audio_seq_pkg.sv
// audio_seq_pkg: shared types and note constants for the note sequencer
package audio_seq_pkg;

    typedef enum logic [1:0] {IDLE, PLAY, PAUSE} seq_state_t;

    typedef struct packed {
        logic        on;
        logic        tie;
        logic [15:0] freq;
    } seq_step_t;

    localparam logic [15:0] G4_FREQ  = 16'd4208;
    localparam logic [15:0] DD4_FREQ = 16'd3339;
    localparam logic [15:0] AD4_FREQ = 16'd5005;

endpackage

// File: rtl/seq_step_timer.sv
// seq_step_timer: per-step cycle counter with gate window, frozen while held
module seq_step_timer #(
    parameter int STEP_CYCLES = 3125000,
    parameter int GATE_CYCLES = 2500000
) (
    input  logic clk_i,
    input  logic rstn_i,
    input  logic clear,
    input  logic hold,
    output logic step_end,
    output logic gate_open
);

    localparam int CW = $clog2(STEP_CYCLES);

    logic [CW-1:0] count;
    logic [CW-1:0] count_next;

    assign step_end   = count == CW'(STEP_CYCLES - 1);
    assign count_next = clear ? '0 : hold ? count : step_end ? '0 : count + 1'b1;
    // gate window is judged on the count the outputs will show next cycle
    assign gate_open  = count_next < CW'(GATE_CYCLES);

    // step-cycle counter register
    always_ff @(posedge clk_i) begin
        if (!rstn_i) count <= '0;
        else         count <= count_next;
    end

endmodule

// File: rtl/audio_note_sequencer.sv
// audio_note_sequencer: step-table driven tempo sequencer for a bank of audio channels
module audio_note_sequencer
    import audio_seq_pkg::*;
#(
    parameter int CHANNELS    = 2,
    parameter int STEPS       = 16,
    parameter int FREQ_W      = 16,
    parameter int STEP_CYCLES = 3125000,
    parameter int GATE_CYCLES = 2500000,
    localparam int SW = $clog2(STEPS),
    localparam int CW = CHANNELS > 1 ? $clog2(CHANNELS) : 1
) (
    input  logic                       clk_i,
    input  logic                       rstn_i,
    input  logic                       wr_en_i,
    input  logic [SW-1:0]              wr_addr_i,
    input  logic [CW-1:0]              wr_ch_i,
    input  logic [FREQ_W+1:0]          wr_data_i,
    input  logic [SW-1:0]              len_i,
    input  logic                       loop_i,
    input  logic                       start_i,
    input  logic                       stop_i,
    input  logic                       pause_i,
    output logic [CHANNELS-1:0]        ch_en_o,
    output logic [CHANNELS*FREQ_W-1:0] ch_freq_o,
    output logic [SW-1:0]              step_o,
    output logic                       busy_o,
    output logic                       done_o
);

    localparam int EW = FREQ_W + 2;

    seq_state_t    state;
    seq_state_t    nstate;
    logic [SW-1:0] nstep;
    logic [SW-1:0] len;
    logic          finish;
    logic          wr_ok;
    logic          step_end;
    logic          gate_open;
    logic [EW-1:0] tbl   [STEPS][CHANNELS];
    logic [EW-1:0] entry [CHANNELS];

    assign wr_ok = wr_en_i && state == IDLE && int'(wr_ch_i) < CHANNELS;

    seq_step_timer #(
        .STEP_CYCLES(STEP_CYCLES),
        .GATE_CYCLES(GATE_CYCLES)
    ) timer (
        .clk_i    (clk_i),
        .rstn_i   (rstn_i),
        .clear    (start_i || stop_i || state == IDLE),
        .hold     (state == PAUSE),
        .step_end (step_end),
        .gate_open(gate_open)
    );

    // step table storage; contents survive reset
    always_ff @(posedge clk_i) begin
        if (wr_ok) tbl[wr_addr_i][wr_ch_i] <= wr_data_i;
    end

    // read the step about to play, forwarding a same-cycle write so start sees fresh data
    always_comb begin
        for (int c = 0; c < CHANNELS; c++)
            entry[c] = (wr_ok && wr_addr_i == nstep && int'(wr_ch_i) == c) ? wr_data_i : tbl[nstep][c];
    end

    // next state and step: stop beats start beats pause
    always_comb begin
        nstate = state;
        nstep  = step_o;
        finish = 1'b0;
        if (stop_i) begin
            nstate = IDLE;
            nstep  = '0;
        end else if (start_i) begin
            nstate = PLAY;
            nstep  = '0;
        end else if (state == PLAY) begin
            nstate = pause_i ? PAUSE : PLAY;
            if (step_end) begin
                if (step_o != len) begin
                    nstep = step_o + 1'b1;
                end else if (loop_i) begin
                    nstep = '0;
                end else begin
                    nstate = IDLE;
                    nstep  = '0;
                    finish = 1'b1;
                end
            end
        end else if (state == PAUSE) begin
            nstate = pause_i ? PAUSE : PLAY;
        end
    end

    // FSM state and registered outputs derived from the upcoming step and count
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state     <= IDLE;
            step_o    <= '0;
            len       <= '0;
            ch_en_o   <= '0;
            ch_freq_o <= '0;
            busy_o    <= 1'b0;
            done_o    <= 1'b0;
        end else begin
            state  <= nstate;
            step_o <= nstep;
            busy_o <= nstate != IDLE;
            done_o <= finish;
            if (start_i && !stop_i) len <= len_i;
            for (int c = 0; c < CHANNELS; c++) begin
                ch_en_o[c] <= nstate == PLAY && entry[c][EW-1] && (entry[c][EW-2] || gate_open);
                if (nstate == PLAY && entry[c][EW-1]) ch_freq_o[c*FREQ_W +: FREQ_W] <= entry[c][FREQ_W-1:0];
            end
        end
    end

endmodule

// File: tb/tb_audio_note_sequencer.sv
// tb_audio_note_sequencer: directed self-checking bench for the note sequencer
module tb_audio_note_sequencer;
    import audio_seq_pkg::*;

    localparam int CH = 2;
    localparam int ST = 4;
    localparam int SC = 8;
    localparam int GC = 6;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        wr_en = 1'b0;
    logic [1:0]  wr_addr = '0;
    logic        wr_ch = 1'b0;
    logic [17:0] wr_data = '0;
    logic [1:0]  len = '0;
    logic        loop = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        pause = 1'b0;
    logic [1:0]  ch_en;
    logic [31:0] ch_freq;
    logic [1:0]  step;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;
    seq_step_t   tbl [ST][CH];
    logic [15:0] last_freq [CH];

    audio_note_sequencer #(
        .CHANNELS(CH),
        .STEPS(ST),
        .FREQ_W(16),
        .STEP_CYCLES(SC),
        .GATE_CYCLES(GC)
    ) dut (
        .clk_i    (clk),
        .rstn_i   (rstn),
        .wr_en_i  (wr_en),
        .wr_addr_i(wr_addr),
        .wr_ch_i  (wr_ch),
        .wr_data_i(wr_data),
        .len_i    (len),
        .loop_i   (loop),
        .start_i  (start),
        .stop_i   (stop),
        .pause_i  (pause),
        .ch_en_o  (ch_en),
        .ch_freq_o(ch_freq),
        .step_o   (step),
        .busy_o   (busy),
        .done_o   (done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int a, input int c, input seq_step_t d);
        wr_en = 1'b1;
        wr_addr = 2'(a);
        wr_ch = 1'(c);
        wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic do_start(input int l, input logic lp);
        len = 2'(l);
        loop = lp;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic check_idle(input string tag, input logic exp_done);
        check({tag, " done"}, done, exp_done);
        check({tag, " busy"}, busy, 0);
        check({tag, " en"}, ch_en, 0);
        check({tag, " freq0"}, ch_freq[15:0], last_freq[0]);
        check({tag, " freq1"}, ch_freq[31:16], last_freq[1]);
    endtask

    // walk play cycles t against the table model; optional loop clear and pause window
    task automatic play(input int cycles, input int clear_at, input int pause_at, input int pause_len);
        int s;
        int k;
        seq_step_t e;
        for (int t = 0; t < cycles; t++) begin
            s = (t / SC) % ST;
            k = t % SC;
            check($sformatf("step t%0d", t), step, s);
            check($sformatf("busy t%0d", t), busy, 1);
            check($sformatf("done t%0d", t), done, 0);
            for (int c = 0; c < CH; c++) begin
                e = tbl[s][c];
                if (e.on) last_freq[c] = e.freq;
                check($sformatf("en%0d t%0d", c, t), ch_en[c], e.on && (e.tie || k < GC));
                check($sformatf("freq%0d t%0d", c, t), ch_freq[c*16 +: 16], last_freq[c]);
            end
            if (t == clear_at) loop = 1'b0;
            if (t == pause_at) begin
                pause = 1'b1;
                tick();
                for (int i = 0; i < pause_len; i++) begin
                    check($sformatf("pause step %0d", i), step, s);
                    check($sformatf("pause en %0d", i), ch_en, 0);
                    check($sformatf("pause busy %0d", i), busy, 1);
                    check($sformatf("pause freq0 %0d", i), ch_freq[15:0], last_freq[0]);
                    if (i == pause_len - 1) pause = 1'b0;
                    tick();
                end
            end else begin
                tick();
            end
        end
    endtask

    initial begin
        last_freq[0] = '0;
        last_freq[1] = '0;
        tbl[0][0] = '{1'b1, 1'b0, G4_FREQ};
        tbl[1][0] = '{1'b0, 1'b0, 16'd0};
        tbl[2][0] = '{1'b1, 1'b1, DD4_FREQ};
        tbl[3][0] = '{1'b1, 1'b1, AD4_FREQ};
        tbl[0][1] = '{1'b1, 1'b1, AD4_FREQ};
        tbl[1][1] = '{1'b0, 1'b0, 16'd0};
        tbl[2][1] = '{1'b1, 1'b1, AD4_FREQ};
        tbl[3][1] = '{1'b0, 1'b0, 16'd0};
        tick();
        tick();
        check("rst en", ch_en, 0);
        check("rst freq", ch_freq, 0);
        check("rst step", step, 0);
        check("rst busy", busy, 0);
        check("rst done", done, 0);
        rstn = 1'b1;
        tick();
        for (int s = 0; s < ST; s++)
            for (int c = 0; c < CH; c++)
                wr(s, c, tbl[s][c]);
        // one-shot run: gated, rest, two tied steps
        do_start(3, 1'b0);
        play(32, -1, -1, 0);
        check_idle("run1 end", 1'b1);
        tick();
        check("run1 done drop", done, 0);
        // looping run, loop cleared during the second pass through step 2
        do_start(3, 1'b1);
        play(64, 50, -1, 0);
        check_idle("loop end", 1'b1);
        tick();
        // pause for 20 cycles with the counter at 3 of step 1
        do_start(3, 1'b0);
        play(32, -1, 10, 20);
        check_idle("pause end", 1'b1);
        tick();
        // write while playing is dropped; stop with start aborts to idle
        do_start(3, 1'b0);
        play(12, -1, -1, 0);
        wr(0, 0, '{1'b1, 1'b0, 16'd1});
        stop = 1'b1;
        start = 1'b1;
        tick();
        stop = 1'b0;
        start = 1'b0;
        check_idle("stop", 1'b0);
        check("stop step", step, 0);
        tick();
        check("stop no done", done, 0);
        // table untouched by the dropped write; reset mid step 2
        do_start(3, 1'b0);
        play(16, -1, -1, 0);
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        last_freq[0] = '0;
        last_freq[1] = '0;
        check_idle("reset", 1'b0);
        check("reset step", step, 0);
        tick();
        // restart after reset replays the same table
        do_start(3, 1'b0);
        play(32, -1, -1, 0);
        check_idle("replay end", 1'b1);
        tick();
        // write landing on the start cycle is used by step 0
        tbl[0][0] = '{1'b1, 1'b1, G4_FREQ};
        wr_en = 1'b1;
        wr_addr = 2'd0;
        wr_ch = 1'b0;
        wr_data = tbl[0][0];
        len = 2'd3;
        loop = 1'b0;
        start = 1'b1;
        tick();
        wr_en = 1'b0;
        start = 1'b0;
        play(32, -1, -1, 0);
        check_idle("wrstart end", 1'b1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/audio_note_sequencer.md
# audio_note_sequencer

Parametrised multi-channel note sequencer that drives the `en_i`/`freq_i` inputs of up to CHANNELS `audio_channel` instances from a programmable step table. It replaces hand-timed note stimulus with a tempo counter, per-step articulation (rest / gated / tied), looping and pause. It sits between the control registers and the channel bank; generator select and volume stay on the channels.

## Interface
- CHANNELS, 2: number of driven audio channels (1..8).
- STEPS, 16: step-table depth (power of two, 2..256).
- FREQ_W, 16: width of the channel frequency word.
- STEP_CYCLES, 3125000: clk_i cycles per step (0.25 s at 12.5 MHz); must be ≥ 2.
- GATE_CYCLES, 2500000: cycles `en` stays high in a gated step; must satisfy 1 ≤ GATE_CYCLES < STEP_CYCLES.
- clk_i  in  1  single clock; all logic is on its rising edge.
- rstn_i  in  1  reset, synchronous, active-low.
- wr_en_i  in  1  step-table write strobe; accepted only in IDLE.
- wr_addr_i  in  $clog2(STEPS)  step index to write.
- wr_ch_i  in  $clog2(CHANNELS) (min 1)  channel to write.
- wr_data_i  in  FREQ_W+2  entry {on, tie, freq}.
- len_i  in  $clog2(STEPS)  index of the last step; latched on start.
- loop_i  in  1  level; when 1, wrap from step len to step 0 instead of finishing.
- start_i  in  1  pulse; begin playback at step 0.
- stop_i  in  1  pulse; abort to IDLE.
- pause_i  in  1  level; freeze position while in playback.
- ch_en_o  out  CHANNELS  per-channel enable, bit c → channel c.
- ch_freq_o  out  CHANNELS*FREQ_W  per-channel frequency, slice c → channel c.
- step_o  out  $clog2(STEPS)  current step index.
- busy_o  out  1  high in PLAY or PAUSE.
- done_o  out  1  one-cycle pulse on normal (non-loop) completion.

## Operation
- Step table: STEPS×CHANNELS entries. Contents are not reset. Entry semantics:
  - on=0: rest for the whole step; `en`=0, freq holds its previous value.
  - on=1, tie=0: gated; `en`=1 for step-cycle counts 0..GATE_CYCLES-1, then 0.
  - on=1, tie=1: `en`=1 for the whole step, so consecutive tied steps give no `en` gap.
- FSM states:
  - IDLE → PLAY on start_i; latch len_i; step=0; counter=0.
  - PLAY → PAUSE when pause_i=1.
  - PAUSE → PLAY when pause_i=0; counter and step resume unchanged.
  - PLAY/PAUSE → IDLE on stop_i.
  - PLAY → IDLE at the end of step len when loop_i=0; done_o=1 in that cycle.
- Counter: 0..STEP_CYCLES-1, advances only in PLAY. At STEP_CYCLES-1 the step increments, or wraps to 0 when step == latched len and loop_i=1; loop_i is sampled at this point.
- Priority: rstn_i > stop_i > start_i > pause_i. start_i while busy restarts at step 0 with newly latched len_i. Simultaneous stop_i and start_i → IDLE.
- Writes in PLAY or PAUSE are ignored. Writes to wr_ch_i ≥ CHANNELS are ignored. A write and a start_i in the same cycle: the write lands and step 0 uses the new data.
- In IDLE and PAUSE, ch_en_o=0. ch_freq_o holds its last value so the generator phase keeps no glitch.

## Timing
- Reset values: ch_en_o=0, ch_freq_o=0, step_o=0, busy_o=0, done_o=0, state=IDLE, counter=0.
- All outputs are registered. start_i sampled at edge N → outputs reflect step 0 (counter 0) from edge N+1; busy_o=1 from N+1.
- A step occupies exactly STEP_CYCLES cycles of PLAY. A gated `en` is high for exactly GATE_CYCLES cycles.
- pause_i=1 sampled at edge N → ch_en_o=0 and counter frozen from N+1; pause time is not counted.
- stop_i at edge N → IDLE outputs from N+1; no done_o.
- done_o is high in the first IDLE cycle after the final step, together with busy_o=0.
- Reset asserted mid-playback → reset values at the next edge.

## Structure
- Package `audio_seq_pkg`:
  - `seq_state_t` enum {IDLE, PLAY, PAUSE}.
  - `seq_step_t` packed struct {on, tie, freq[15:0]}.
  - Note constants G4_FREQ=4208, DD4_FREQ=3339, AD4_FREQ=5005.
- One sub-module, `seq_step_timer`: step-cycle counter with gate comparison. It outputs step_end and gate_open, and has a hold input driven by pause.
- The step table is a plain register array with combinational read; it is not a RAM macro.

## Test plan
Bench parameters: CHANNELS=2, STEPS=4, STEP_CYCLES=8, GATE_CYCLES=6.
- Program ch0 steps 0..3 = gated G4, rest, tied DD4, tied AD4; len=3, loop=0; start → ch_en_o[0]: 6 high, 2 low, 8 low, then 16 continuous high; freq 4208, 4208, 3339, 5005. done_o pulses at cycle 33 after start; busy_o=0 after.
- Same table with loop=1 → step_o sequence 0,1,2,3,0,1… every 8 cycles; done_o never asserted. Clear loop during step 2 → finishes after step 3.
- Pause for 20 cycles at counter=3 of step 1 → ch_en_o=0 and step_o=1 throughout; after release, step 1 lasts 5 more cycles.
- Assert stop_i and start_i in the same cycle mid-play → IDLE, ch_en_o=0, done_o=0. Writes during play (addr 0, freq 1) leave the table unchanged on the next run.
- Assert rstn_i=0 at step 2 → all outputs at reset values next edge. Restart after reset replays the unchanged table.
- Drive ch1 with independent entries (AD4 tied, rest alternating) → ch1 en/freq match its entries cycle-exactly, with no cross-talk into ch0.
